// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding and word framing.
package boot_pkg;
   typedef enum logic [2:0] {HDR_I, LOAD_I, HDR_D, LOAD_D, DONE, RUN, ERROR} boot_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
endpackage

// File: rtl/boot_controller_byte_word_assembler.sv
// Packs accepted RX bytes MSB-first into 32-bit words; word_valid is combinational
// and marks the cycle whose accepted byte completes a word.
module byte_word_assembler
   import boot_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        accept,
   input  logic [7:0]  rx_byte,
   output logic        word_valid,
   output logic [31:0] word
);
   logic [BYTE_CNT_W-1:0] byte_cnt;
   logic [23:0]           shift_q;

   assign word       = {shift_q, rx_byte};
   assign word_valid = accept && (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_cnt <= '0;
         shift_q  <= '0;
      end else if (accept) begin
         byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
         shift_q  <= {shift_q[15:0], rx_byte};
      end
   end
endmodule

// File: rtl/boot_controller.sv
// Loads instruction and data images from the RX byte stream, then hands RX pop and SRAM to the CPU.
// Write strobes follow the 4th byte by one cycle; RX is drained whenever rx_valid outside RUN.
module boot_controller
   import boot_pkg::*;
#(
   parameter int                 IMEM_AW   = 16,
   parameter int                 DMEM_AW   = 32,
   parameter logic [DMEM_AW-1:0] DMEM_BASE = '0
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               rx_valid,
   input  logic [7:0]         rx_data,
   output logic               rx_pop,
   input  logic               cpu_rx_pop,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [31:0]        imem_wdata,
   input  logic               cpu_sram_we,
   input  logic [DMEM_AW-1:0] cpu_sram_addr,
   input  logic [31:0]        cpu_sram_wdata,
   output logic               sram_we,
   output logic [DMEM_AW-1:0] sram_addr,
   output logic [31:0]        sram_wdata,
   input  logic               cpu_halt,
   output logic               in_execution,
   output logic               error
);
   boot_state_t        state_q, state_d;
   logic [31:0]        count_q, count_d;
   logic [31:0]        idx_q, idx_d;
   logic               imem_we_q, imem_we_d;
   logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]        imem_wdata_q, imem_wdata_d;
   logic               ld_we_q, ld_we_d;
   logic [DMEM_AW-1:0] ld_addr_q, ld_addr_d;
   logic [31:0]        ld_wdata_q, ld_wdata_d;

   logic        run;
   logic        accept;
   logic        word_valid;
   logic [31:0] word;
   logic        last_word;
   logic        oversize;

   assign run    = (state_q == RUN);
   assign accept = rx_valid && !run;
   assign rx_pop = run ? cpu_rx_pop : rx_valid;

   byte_word_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .accept     (accept),
      .rx_byte    (rx_data),
      .word_valid (word_valid),
      .word       (word)
   );

   assign last_word = (idx_q == count_q - 32'd1);
   // 33-bit compare so a full 2^IMEM_AW image is still accepted
   assign oversize  = ({1'b0, word} > (33'd1 << IMEM_AW));

   assign imem_we      = imem_we_q;
   assign imem_addr    = imem_addr_q;
   assign imem_wdata   = imem_wdata_q;
   assign sram_we      = run ? cpu_sram_we    : ld_we_q;
   assign sram_addr    = run ? cpu_sram_addr  : ld_addr_q;
   assign sram_wdata   = run ? cpu_sram_wdata : ld_wdata_q;
   assign in_execution = run;
   assign error        = (state_q == ERROR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= HDR_I;
         count_q      <= '0;
         idx_q        <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         ld_we_q      <= 1'b0;
         ld_addr_q    <= '0;
         ld_wdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         idx_q        <= idx_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         ld_we_q      <= ld_we_d;
         ld_addr_q    <= ld_addr_d;
         ld_wdata_q   <= ld_wdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      idx_d        = idx_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      ld_we_d      = 1'b0;
      ld_addr_d    = ld_addr_q;
      ld_wdata_d   = ld_wdata_q;
      case (state_q)
         HDR_I: if (word_valid) begin
            count_d = word;
            idx_d   = '0;
            if (oversize)        state_d = ERROR;
            else if (word == '0) state_d = HDR_D;
            else                 state_d = LOAD_I;
         end
         LOAD_I: if (word_valid) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = idx_q[IMEM_AW-1:0];
            imem_wdata_d = word;
            if (last_word) begin
               idx_d   = '0;
               state_d = HDR_D;
            end else begin
               idx_d = idx_q + 32'd1;
            end
         end
         HDR_D: if (word_valid) begin
            count_d = word;
            idx_d   = '0;
            state_d = (word == '0) ? DONE : LOAD_D;
         end
         LOAD_D: if (word_valid) begin
            ld_we_d    = 1'b1;
            ld_addr_d  = DMEM_BASE + DMEM_AW'(idx_q);
            ld_wdata_d = word;
            if (last_word) begin
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 32'd1;
            end
         end
         DONE:  state_d = RUN;
         RUN: if (cpu_halt) begin
            idx_d   = '0;
            state_d = HDR_I;
         end
         ERROR:   state_d = ERROR;
         default: state_d = HDR_I;
      endcase
   end
endmodule

// File: doc/boot_controller.md
Name: boot_controller

Overview:
Sequences the boot phase of the CPU top level.
- Drains the shared RS-232C receive FIFO.
- Assembles big-endian 32-bit words.
- Loads the program into instruction memory and the initial data image into SRAM.
- Then hands both the RX FIFO pop and the SRAM port over to the CPU by asserting in_execution.
- Replaces the ad-hoc rx_fifo_pop and memory muxing around the top level. Returns to load mode on cpu_halt.

Parameters:
IMEM_AW, 16, instruction memory word-address width; capacity 2^IMEM_AW words
DMEM_AW, 32, SRAM address width
DMEM_BASE, 0, SRAM word address of the first data word

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_valid  in  1  RX FIFO non-empty (registered !rx_waiting)
rx_data  in  8  RX FIFO head byte
rx_pop  out  1  RX FIFO pop
cpu_rx_pop  in  1  CPU pop request (honoured only in RUN)
imem_we  out  1  instruction memory write strobe
imem_addr  out  IMEM_AW  instruction write word address
imem_wdata  out  32  instruction word
cpu_sram_we  in  1  CPU SRAM write enable
cpu_sram_addr  in  DMEM_AW  CPU SRAM address
cpu_sram_wdata  in  32  CPU SRAM write data
sram_we  out  1  SRAM write enable to pads
sram_addr  out  DMEM_AW  SRAM address to pads
sram_wdata  out  32  SRAM write data to pads
cpu_halt  in  1  one-cycle pulse: CPU requests reload
in_execution  out  1  CPU may fetch/run; gates PC and instruction address mux
error  out  1  sticky oversize-program error

Behaviour:
- Reset (reset=0, async) forces:
  - state HDR_I
  - byte counter 0
  - all strobes 0, in_execution 0, error 0
  - addresses and data 0
- Stream format: 4-byte N_inst, N_inst words, 4-byte N_data, N_data words. All fields big-endian, first byte is MSB.
- Byte accept:
  - Outside RUN: rx_pop = rx_valid, combinational. A byte is consumed on each edge where rx_valid=1.
  - In RUN: rx_pop = cpu_rx_pop.
- Byte counter is 2 bits and wraps 3->0. The word completes on the edge accepting byte 3.
- States:
  - HDR_I: on word complete, latch N_inst and clear the word index.
    - N_inst > 2^IMEM_AW -> ERROR.
    - N_inst = 0 -> HDR_D.
    - Otherwise -> LOAD_I.
  - LOAD_I: each complete word raises imem_we for exactly the following cycle, with imem_addr = index and imem_wdata = word; index then increments. The last word -> HDR_D.
  - HDR_D: on word complete, latch N_data.
    - N_data = 0 -> DONE.
    - Otherwise -> LOAD_D.
  - LOAD_D: same as LOAD_I, but drives sram_we/sram_addr (DMEM_BASE + index)/sram_wdata. The last word -> DONE.
  - DONE: a single cycle. The final write pulse is visible here. Next state is RUN.
  - RUN: in_execution=1. sram_* = cpu_sram_* (combinational mux). cpu_halt -> HDR_I; in_execution falls on that edge.
  - ERROR: error=1, in_execution=0. rx_pop = rx_valid, draining without writes. Exits only on reset.
- Latency: a write strobe appears 1 cycle after the edge that accepts the 4th byte. in_execution rises 1 cycle after the final write strobe.
- Back-to-back bytes are allowed. The byte for the next word may be accepted in the same cycle as the previous word's write strobe.
- Outside RUN, cpu_sram_we and cpu_rx_pop are ignored. In RUN, the loader never drives imem_we.
- N_inst = 2^IMEM_AW is legal. The index wraps to 0 after the last write; no further write occurs.
- Reset mid-load discards partial words and counts.

Decomposition:
- Shared package (boot_pkg):
  - state encoding constants: HDR_I, LOAD_I, HDR_D, LOAD_D, DONE, RUN, ERROR
  - BYTES_PER_WORD = 4
- Natural sub-module: byte_word_assembler.
  - Contains the byte counter, the shift register and the word_valid pulse.
  - Uses the same clk/reset.

Test Plan:
- Reset, then release with rx_valid=0 -> all outputs 0, rx_pop=0, no strobes for 20 cycles.
- Stream 00 00 00 02 | 11 22 33 44 | AA BB CC DD | 00 00 00 00, back-to-back -> required response:
  - imem_we at addr 0 = 0x11223344, then at addr 1 = 0xAABBCCDD
  - no sram_we
  - in_execution high 1 cycle after DONE
- Stream 00 00 00 01 | 00 00 00 00 | 00 00 00 01 | DE AD BE EF, with rx_valid low 3 cycles between every byte -> required response:
  - one imem_we at addr 0
  - one sram_we at addr DMEM_BASE = 0xDEADBEEF
  - exactly 16 rx_pop pulses
- N_inst = 00 01 00 01 (IMEM_AW=16) -> error=1, no writes, subsequent bytes drained, in_execution stays 0.
- In RUN, drive cpu_sram_we=1, addr=0x40, data=0x5 and cpu_rx_pop=1 -> sram_* and rx_pop mirror them in the same cycle. Then pulse cpu_halt -> in_execution=0 next cycle and a new load is accepted.
- Assert reset after 2 of 4 bytes of an instruction word -> outputs cleared immediately. After release, a full fresh stream loads correctly from addr 0.
